// File: rtl/shift_pkg.sv
// ----------------------------------------------------------------------------
// shift_pkg
// Shared types and constants for the shift arbiter slice.
//   shift_op_t  : per-request operation encoding (SRL, SRA, SLL, ROTR)
//   arb_state_t : arbiter result-slot state (IDLE, ROT2, HOLD)
//   bit_rev     : helper that mirrors a datapath word, used to build SLL
//                 out of the right shifter
// ----------------------------------------------------------------------------
package shift_pkg;

    localparam int SHIFT_W = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        SH_SRL  = 2'b00,
        SH_SRA  = 2'b01,
        SH_SLL  = 2'b10,
        SH_ROTR = 2'b11
    } shift_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ROT2 = 2'b01,
        HOLD = 2'b10
    } arb_state_t;

    // Mirror a word end-for-end: bit i moves to bit SHIFT_W-1-i.
    function automatic logic [SHIFT_W-1:0] bit_rev(input logic [SHIFT_W-1:0] v);
        logic [SHIFT_W-1:0] r;
        r = {SHIFT_W{1'b0}};
        for (int i = 0; i < SHIFT_W; i++) begin
            r[i] = v[SHIFT_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_core.sv
// ----------------------------------------------------------------------------
// shift_core
// Purely combinational 32-bit logarithmic right shifter with a selectable
// fill bit. Left shifts reuse the same stages by mirroring the operand on
// the way in and the result on the way out.
// Ports:
//   a     in  SHIFT_W  operand
//   shamt in  SHAMT_W  shift amount
//   op    in  2        shift_op_t; SH_ROTR is shifted as SRL (a rotate is
//                      assembled by the arbiter from two passes)
//   y     out SHIFT_W  result
// ----------------------------------------------------------------------------
module shift_core
    import shift_pkg::*;
(
    input  logic [SHIFT_W-1:0] a,
    input  logic [SHAMT_W-1:0] shamt,
    input  shift_op_t          op,
    output logic [SHIFT_W-1:0] y
);

    logic                            rev_s;
    logic                            fill_s;
    logic [SHAMT_W:0][SHIFT_W-1:0]   stage_s;

    // Decode mirroring and fill bit from the operation.
    always_comb begin
        rev_s  = 1'b0;
        fill_s = 1'b0;
        case (op)
            SH_SRL:  begin rev_s = 1'b0; fill_s = 1'b0;          end
            SH_SRA:  begin rev_s = 1'b0; fill_s = a[SHIFT_W-1];  end
            SH_SLL:  begin rev_s = 1'b1; fill_s = 1'b0;          end
            SH_ROTR: begin rev_s = 1'b0; fill_s = 1'b0;          end
            default: begin rev_s = 1'b0; fill_s = 1'b0;          end
        endcase
    end

    assign stage_s[0] = rev_s ? bit_rev(a) : a;

    // Stage k shifts right by 2**k when shamt[k] is set.
    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        localparam int D = 1 << k;
        assign stage_s[k+1] = shamt[k] ? {{D{fill_s}}, stage_s[k][SHIFT_W-1:D]}
                                       : stage_s[k];
    end

    assign y = rev_s ? bit_rev(stage_s[SHAMT_W]) : stage_s[SHAMT_W];

endmodule

// File: rtl/shift_arbiter.sv
// ----------------------------------------------------------------------------
// shift_arbiter
// Shares one shift_core between two requesters (0: ALU shift path, 1: second
// client). One result slot; the result is registered and tagged with the
// owning requester. A new request can be taken in the same cycle the held
// result retires, giving one result per cycle under continuous load.
//
// Optional feature (compile macro SHIFT_ARB_ROTATE_EN):
//   ROTR runs as two passes through the single shifter: SRL by s into a
//   partial register (state ROT2), then SLL of the latched operand by
//   (32-s) mod 32 OR'd with the partial. shamt=0 stays single pass.
//   Without the macro, ROTR is shifted as SRL in a single pass.
//
// Parameters:
//   PRIO_MODE  0 = round-robin, 1 = fixed priority (req 0 wins)
//   SHIFT_W    datapath width, must be 32
// Ports:
//   clk        in  1        clock, rising edge
//   reset_n    in  1        asynchronous active-low reset
//   req_valid  in  2        per-requester request valid
//   req_ready  out 2        per-requester accept, one-hot or zero
//   req_a      in  2x32     operand per requester
//   req_shamt  in  2x5      shift amount per requester
//   req_op     in  2x2      shift_op_t per requester
//   rsp_valid  out 1        result valid
//   rsp_ready  in  1        consumer accepts the result
//   rsp_id     out 1        requester owning the result
//   rsp_data   out 32       shifted result
// ----------------------------------------------------------------------------
module shift_arbiter #(
    parameter int PRIO_MODE = 0,
    parameter int SHIFT_W   = 32
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic [1:0]                             req_valid,
    output logic [1:0]                             req_ready,
    input  logic [1:0][SHIFT_W-1:0]                req_a,
    input  logic [1:0][shift_pkg::SHAMT_W-1:0]     req_shamt,
    input  logic [1:0][1:0]                        req_op,
    output logic                                   rsp_valid,
    input  logic                                   rsp_ready,
    output logic                                   rsp_id,
    output logic [SHIFT_W-1:0]                     rsp_data
);

    import shift_pkg::*;

    if (SHIFT_W != 32) begin : g_bad_width
        $error("shift_arbiter: SHIFT_W must be 32");
    end

    arb_state_t          state_r;
    arb_state_t          state_nxt_s;
    arb_state_t          accept_state_s;
    logic                last_grant_r;
    logic                rsp_valid_r;
    logic                rsp_id_r;
    logic [SHIFT_W-1:0]  rsp_data_r;

    logic                slot_free_s;
    logic                accept_s;
    logic                gnt_id_s;
    shift_op_t           gnt_op_s;

    logic [SHIFT_W-1:0]  core_a_s;
    logic [SHAMT_W-1:0]  core_shamt_s;
    shift_op_t           core_op_s;
    logic [SHIFT_W-1:0]  core_y_s;

    // Rotate sequencing hooks; constant when the rotate feature is absent.
    logic                rot_start_s;
    logic                rot_fin_s;
    logic                rot_fin_id_s;
    logic [SHIFT_W-1:0]  rot_fin_data_s;

    // Arbitration: pick the winner among valid requesters.
    always_comb begin
        gnt_id_s = 1'b0;
        if (req_valid == 2'b11) begin
            if (PRIO_MODE == 1) begin
                gnt_id_s = 1'b0;
            end else begin
                gnt_id_s = ~last_grant_r;
            end
        end else if (req_valid[1]) begin
            gnt_id_s = 1'b1;
        end else begin
            gnt_id_s = 1'b0;
        end
    end

    // The slot opens when empty or when the held result retires this cycle.
    assign slot_free_s = (state_r == IDLE) || ((state_r == HOLD) && rsp_ready);
    assign accept_s    = reset_n && slot_free_s && (req_valid != 2'b00);
    assign req_ready   = accept_s ? (gnt_id_s ? 2'b10 : 2'b01) : 2'b00;
    assign gnt_op_s    = shift_op_t'(req_op[gnt_id_s]);

`ifdef SHIFT_ARB_ROTATE_EN
    logic [SHIFT_W-1:0]  rot_a_r;
    logic [SHAMT_W-1:0]  rot_s_r;
    logic                rot_id_r;
    logic [SHIFT_W-1:0]  partial_r;

    assign rot_start_s    = accept_s && (gnt_op_s == SH_ROTR) &&
                            (req_shamt[gnt_id_s] != {SHAMT_W{1'b0}});
    assign rot_fin_s      = (state_r == ROT2);
    assign rot_fin_id_s   = rot_id_r;
    assign rot_fin_data_s = core_y_s | partial_r;
    assign accept_state_s = rot_start_s ? ROT2 : HOLD;

    // Shared-shifter input mux: second rotate pass, else the granted request.
    always_comb begin
        core_a_s     = req_a[gnt_id_s];
        core_shamt_s = req_shamt[gnt_id_s];
        core_op_s    = gnt_op_s;
        if (state_r == ROT2) begin
            core_a_s     = rot_a_r;
            // (32 - s) mod 32 falls out of 5-bit wraparound.
            core_shamt_s = {SHAMT_W{1'b0}} - rot_s_r;
            core_op_s    = SH_SLL;
        end else begin
            core_a_s     = req_a[gnt_id_s];
            core_shamt_s = req_shamt[gnt_id_s];
            core_op_s    = gnt_op_s;
        end
    end

    // Latch operand, amount, owner and first-pass SRL result of a rotate.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rot_a_r   <= {SHIFT_W{1'b0}};
            rot_s_r   <= {SHAMT_W{1'b0}};
            rot_id_r  <= 1'b0;
            partial_r <= {SHIFT_W{1'b0}};
        end else if (rot_start_s) begin
            rot_a_r   <= req_a[gnt_id_s];
            rot_s_r   <= req_shamt[gnt_id_s];
            rot_id_r  <= gnt_id_s;
            partial_r <= core_y_s;
        end
    end
`else
    assign rot_start_s    = 1'b0;
    assign rot_fin_s      = 1'b0;
    assign rot_fin_id_s   = 1'b0;
    assign rot_fin_data_s = {SHIFT_W{1'b0}};
    assign accept_state_s = HOLD;

    // Shared-shifter input mux: always the granted request.
    always_comb begin
        core_a_s     = req_a[gnt_id_s];
        core_shamt_s = req_shamt[gnt_id_s];
        core_op_s    = gnt_op_s;
    end
`endif

    shift_core u_core (
        .a     (core_a_s),
        .shamt (core_shamt_s),
        .op    (core_op_s),
        .y     (core_y_s)
    );

    // Next-state logic for the result slot.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = accept_state_s;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
`ifdef SHIFT_ARB_ROTATE_EN
            ROT2: begin
                state_nxt_s = HOLD;
            end
`endif
            HOLD: begin
                if (rsp_ready) begin
                    if (accept_s) begin
                        state_nxt_s = accept_state_s;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Result slot and round-robin pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid_r  <= 1'b0;
            rsp_id_r     <= 1'b0;
            rsp_data_r   <= {SHIFT_W{1'b0}};
            last_grant_r <= 1'b1;
        end else begin
            if (accept_s) begin
                last_grant_r <= gnt_id_s;
            end
            if (rot_fin_s) begin
                rsp_valid_r <= 1'b1;
                rsp_id_r    <= rot_fin_id_s;
                rsp_data_r  <= rot_fin_data_s;
            end else if (accept_s && !rot_start_s) begin
                rsp_valid_r <= 1'b1;
                rsp_id_r    <= gnt_id_s;
                rsp_data_r  <= core_y_s;
            end else if (rsp_ready) begin
                // Retired with nothing new, or a rotate just started.
                rsp_valid_r <= 1'b0;
            end
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_data  = rsp_data_r;

endmodule
